// File: rtl/macro_alu_pipe.sv
// Purpose: NCH-channel, WIDTH-bit two-stage ALU pipeline with per-channel accumulators.
// Latency: 2 cycles from input transfer to out_valid; full throughput of 1 set per cycle.
// Backpressure: valid/ready; holds at most 2 entries under stall, freezes completely when active=0.
//
// Ports:
//   wb_clk_i, wb_rst_ni         clock, async active-low reset
//   active                      macro enable; when low, outputs read 0, pads tri-stated, state held
//   in_valid/in_ready           operand handshake (a_i, b_i, sel_i, acc_en_i packed per channel)
//   out_valid/out_ready         result handshake (res_o, carry_o, x_o, y_o)
//   txn_cnt_o                   wrapping count of completed output handshakes
//   io_oeb_o                    pad output-enable-bar for result, carry, x and y pads
module macro_alu_pipe #(
    parameter int WIDTH = 4,
    parameter int NCH   = 2
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_ni,
    input  logic                           active,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NCH*WIDTH-1:0]           a_i,
    input  logic [NCH*WIDTH-1:0]           b_i,
    input  logic [NCH*3-1:0]               sel_i,
    input  logic [NCH-1:0]                 acc_en_i,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NCH*WIDTH-1:0]           res_o,
    output logic [NCH-1:0]                 carry_o,
    output logic [WIDTH-1:0]               x_o,
    output logic                           y_o,
    output logic [15:0]                    txn_cnt_o,
    output logic [NCH*WIDTH+NCH+WIDTH:0]   io_oeb_o
);

    localparam int OEBW = NCH*WIDTH + NCH + WIDTH + 1;

    // S1: registered operands
    logic                 s1_valid;
    logic [NCH*WIDTH-1:0] s1_a;
    logic [NCH*WIDTH-1:0] s1_b;
    logic [NCH*3-1:0]     s1_sel;
    logic [NCH-1:0]       s1_acc;

    // S2: registered results
    logic                 s2_valid;
    logic [NCH*WIDTH-1:0] s2_res;
    logic [NCH-1:0]       s2_carry;

    logic [WIDTH-1:0]     acc_q [NCH];
    logic [15:0]          txn_cnt;

    logic                 s2_adv;
    logic                 s1_adv;
    logic [NCH*WIDTH-1:0] alu_res;
    logic [NCH-1:0]       alu_carry;
    logic [WIDTH-1:0]     x_all;

    assign s2_adv   = active && (!s2_valid || out_ready);
    assign s1_adv   = active && (!s1_valid || s2_adv);
    assign in_ready = s1_adv;

    // Per-channel ALU on the S1 entry. The accumulator is read here, at the
    // moment the entry moves into S2, so it already reflects the entry ahead.
    always_comb begin
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [WIDTH-1:0] r;
        logic [WIDTH:0]   sum;
        logic             cy;
        alu_res   = '0;
        alu_carry = '0;
        op_a      = '0;
        op_b      = '0;
        r         = '0;
        sum       = '0;
        cy        = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            op_a = s1_acc[c] ? acc_q[c] : s1_a[c*WIDTH +: WIDTH];
            op_b = s1_b[c*WIDTH +: WIDTH];
            sum  = '0;
            r    = '0;
            cy   = 1'b0;
            case (s1_sel[c*3 +: 3])
                3'b000: begin
                    sum = {1'b0, op_a} + {1'b0, op_b};
                    r   = sum[WIDTH-1:0];
                    cy  = sum[WIDTH];
                end
                3'b001: begin
                    // carry out of A + ~B + 1 is the inverted borrow
                    sum = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);
                    r   = sum[WIDTH-1:0];
                    cy  = sum[WIDTH];
                end
                3'b010: r = op_a & op_b;
                3'b011: r = op_a | op_b;
                3'b100: r = op_a ^ op_b;
                3'b110: begin
                    r  = {op_a[WIDTH-2:0], 1'b0};
                    cy = op_a[WIDTH-1];
                end
                3'b111: begin
                    r  = {1'b0, op_a[WIDTH-1:1]};
                    cy = op_a[0];
                end
                default: r = ~op_a;
            endcase
            alu_res[c*WIDTH +: WIDTH] = r;
            alu_carry[c]              = cy;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sel   <= '0;
            s1_acc   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= a_i;
                s1_b   <= b_i;
                s1_sel <= sel_i;
                s1_acc <= acc_en_i;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_carry <= '0;
            for (int c = 0; c < NCH; c++) begin
                acc_q[c] <= '0;
            end
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res   <= alu_res;
                s2_carry <= alu_carry;
                for (int c = 0; c < NCH; c++) begin
                    acc_q[c] <= alu_res[c*WIDTH +: WIDTH];
                end
            end
        end
    end

    // out_valid is already gated by active, so the count freezes when inactive
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            txn_cnt <= '0;
        end else if (out_valid && out_ready) begin
            txn_cnt <= txn_cnt + 16'd1;
        end
    end

    always_comb begin
        x_all = '0;
        for (int c = 0; c < NCH; c++) begin
            x_all = x_all ^ s2_res[c*WIDTH +: WIDTH];
        end
    end

    assign out_valid = active && s2_valid;
    assign res_o     = active ? s2_res   : '0;
    assign carry_o   = active ? s2_carry : '0;
    assign x_o       = active ? x_all    : '0;
    assign y_o       = active && (^x_all);
    assign txn_cnt_o = txn_cnt;
    assign io_oeb_o  = {OEBW{~active}};

endmodule

// File: tb/tb_macro_alu_pipe.sv
// Purpose: randomized + directed check of macro_alu_pipe against a queue-based reference model.
// Latency: model expects a result 2 active cycles after acceptance.
// Backpressure: model allows 2 outstanding entries; in_ready/out_valid predicted from occupancy.
module tb_macro_alu_pipe;
    localparam int W  = 4;
    localparam int N  = 2;
    localparam int OW = N*W + N + W + 1;
    localparam int M  = 1 << W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             active;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   a;
    logic [N*W-1:0]   b;
    logic [N*3-1:0]   sel;
    logic [N-1:0]     acc_en;
    logic             out_valid;
    logic             out_ready;
    logic [N*W-1:0]   res_o;
    logic [N-1:0]     carry_o;
    logic [W-1:0]     x_o;
    logic             y_o;
    logic [15:0]      txn_cnt_o;
    logic [OW-1:0]    io_oeb_o;

    always #5 clk = ~clk;

    macro_alu_pipe #(.WIDTH(W), .NCH(N)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .active   (active),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_i      (a),
        .b_i      (b),
        .sel_i    (sel),
        .acc_en_i (acc_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res_o    (res_o),
        .carry_o  (carry_o),
        .x_o      (x_o),
        .y_o      (y_o),
        .txn_cnt_o(txn_cnt_o),
        .io_oeb_o (io_oeb_o)
    );

    typedef struct {
        logic [N*W-1:0] res;
        logic [N-1:0]   cy;
        int             t;
    } exp_t;

    exp_t         q[$];
    int           acc_m [N];
    int           exp_cnt;
    int           act_cyc;
    int           n_acc;
    logic [W-1:0] log0[$];
    logic         log0c[$];
    int           n_chk  = 0;
    int           n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Opcode semantics as plain integer arithmetic
    function automatic void alu_ref(input int av, input int bv, input int op,
                                    output int r, output int cy);
        cy = 0;
        case (op)
            0: begin r = (av + bv) % M; cy = ((av + bv) >= M) ? 1 : 0; end
            1: begin r = (av - bv + M) % M; cy = (av >= bv) ? 1 : 0; end
            2: r = av & bv;
            3: r = av | bv;
            4: r = av ^ bv;
            5: r = (M - 1) - av;
            6: begin r = (av * 2) % M; cy = (av >= M/2) ? 1 : 0; end
            default: begin r = av / 2; cy = av % 2; end
        endcase
    endfunction

    task automatic set_ch(input int c, input int av, input int bv, input int op, input int ae);
        a[c*W +: W]   = W'(av);
        b[c*W +: W]   = W'(bv);
        sel[c*3 +: 3] = 3'(op);
        acc_en[c]     = (ae != 0);
    endtask

    task automatic clear_model();
        q.delete();
        for (int c = 0; c < N; c++) acc_m[c] = 0;
        exp_cnt = 0;
    endtask

    // One clock: observe at the falling edge, predict, then advance past the rising edge.
    task automatic cycle();
        exp_t         e;
        int           r;
        int           cy;
        int           av;
        logic [W-1:0] xx;
        logic         act;
        @(negedge clk);
        act = active;
        if (!act) begin
            check("idle_out_valid", out_valid, 0);
            check("idle_in_ready", in_ready, 0);
            check("idle_res", res_o, 0);
            check("idle_carry", carry_o, 0);
            check("idle_x", x_o, 0);
            check("idle_y", y_o, 0);
            check("idle_oeb", io_oeb_o, (1 << OW) - 1);
        end else begin
            check("in_ready", in_ready, (q.size() < 2 || out_ready));
            check("out_valid", out_valid, (q.size() > 0 && (act_cyc - q[0].t) >= 2));
            check("oeb_active", io_oeb_o, 0);
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                check("res", res_o, e.res);
                check("carry", carry_o, e.cy);
                xx = '0;
                for (int c = 0; c < N; c++) xx = xx ^ e.res[c*W +: W];
                check("x", x_o, xx);
                check("y", y_o, ^xx);
                check("txn_cnt", txn_cnt_o, exp_cnt);
                exp_cnt = (exp_cnt + 1) & 16'hFFFF;
                log0.push_back(e.res[W-1:0]);
                log0c.push_back(e.cy[0]);
            end
            if (in_valid && in_ready) begin
                n_acc++;
                for (int c = 0; c < N; c++) begin
                    av = acc_en[c] ? acc_m[c] : int'(a[c*W +: W]);
                    alu_ref(av, int'(b[c*W +: W]), int'(sel[c*3 +: 3]), r, cy);
                    acc_m[c]       = r;
                    e.res[c*W +: W] = W'(r);
                    e.cy[c]        = cy[0];
                end
                e.t = act_cyc;
                q.push_back(e);
            end
        end
        @(posedge clk);
        if (act) act_cyc++;
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_model();
    endtask

    logic [N*W-1:0] saved_res;
    int             base;
    int             guard;

    initial begin
        rst_n = 1'b0; active = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sel = '0; acc_en = '0;
        act_cyc = 0; n_acc = 0;
        clear_model();
        do_reset();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_txn", txn_cnt_o, 0);
        check("rst_res", res_o, 0);
        check("rst_carry", carry_o, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_oeb", io_oeb_o, 0);

        // Directed vector: ch0 add F+1, ch1 sub 3-5
        set_ch(0, 4'hF, 4'h1, 0, 0);
        set_ch(1, 4'h3, 4'h5, 1, 0);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("lat_not_early", out_valid, 0);
        cycle();
        check("lat_valid", out_valid, 1);
        check("vec_res", res_o, 8'hE0);
        check("vec_carry", carry_o, 2'b01);
        check("vec_x", x_o, 4'hE);
        check("vec_y", y_o, 1);
        cycle();

        // Backpressure: only two entries accepted
        out_ready = 1'b0;
        in_valid  = 1'b1;
        base      = n_acc;
        for (int i = 1; i <= 4; i++) begin
            set_ch(0, i, 0, 0, 0);
            set_ch(1, i, 0, 0, 0);
            cycle();
        end
        check("bp_accepted", n_acc - base, 2);
        check("bp_in_ready", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
        check("bp_order1", log0[log0.size()-2], 1);
        check("bp_order2", log0[log0.size()-1], 2);
        in_valid = 1'b1;
        set_ch(0, 5, 0, 0, 0);
        base = n_acc;
        cycle();
        check("bp_resume", n_acc - base, 1);
        in_valid = 1'b0;
        repeat (3) cycle();

        // Accumulator chain after reset
        do_reset();
        set_ch(0, 9, 1, 0, 1);
        set_ch(1, 2, 3, 2, 0);
        in_valid = 1'b1;
        repeat (3) cycle();
        set_ch(0, 9, 1, 6, 1);
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        check("acc_r1", log0[log0.size()-4], 4'h1);
        check("acc_r2", log0[log0.size()-3], 4'h2);
        check("acc_r3", log0[log0.size()-2], 4'h3);
        check("acc_shl", log0[log0.size()-1], 4'h6);
        check("acc_shl_carry", log0c[log0c.size()-1], 0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            active    = ($urandom_range(0, 9) != 0);
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            for (int c = 0; c < N; c++)
                set_ch(c, $urandom, $urandom, $urandom_range(0, 7), ($urandom_range(0, 3) == 0));
            cycle();
        end

        // Drain, then hold a result across an inactive window
        active = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) cycle();
        out_ready = 1'b0; in_valid = 1'b1;
        set_ch(0, 7, 6, 4, 0);
        set_ch(1, 12, 3, 1, 0);
        cycle();
        in_valid = 1'b0;
        repeat (2) cycle();
        check("hold_valid", out_valid, 1);
        saved_res = res_o;
        active = 1'b0;
        repeat (5) cycle();
        active = 1'b1;
        #1;
        check("resume_valid", out_valid, 1);
        check("resume_res", res_o, saved_res);
        check("resume_txn", txn_cnt_o, exp_cnt);
        out_ready = 1'b1;
        repeat (2) cycle();

        // Asynchronous reset with two entries in flight
        check("pre_rst_txn_nonzero", txn_cnt_o != 16'h0, 1);
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) cycle();
        in_valid = 1'b0;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_txn", txn_cnt_o, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (5) cycle();

        // Counter wrap: stream at full rate up to 0xFFFE
        in_valid = 1'b1; out_ready = 1'b1;
        set_ch(0, 3, 5, 2, 0);
        set_ch(1, 10, 4, 3, 0);
        guard = 0;
        while (exp_cnt != 16'hFFFE && guard < 70000) begin
            cycle();
            guard++;
        end
        check("wrap_reach", txn_cnt_o, 16'hFFFE);
        cycle();
        check("wrap_ffff", txn_cnt_o, 16'hFFFF);
        cycle();
        check("wrap_zero", txn_cnt_o, 16'h0000);
        in_valid = 1'b0;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/macro_alu_pipe.md
MACRO_ALU_PIPE -- requirements
Module: macro_alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width per channel (legal range 2..16).
REQ-002 The block SHALL have parameter NCH, default 2, giving the number of independent ALU channels (legal range 1..8).
REQ-003 Port wb_clk_i, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 Port wb_rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port active, input, 1: macro enable.
REQ-006 Port in_valid, input, 1: an operand set is presented.
REQ-007 Port in_ready, output, 1: the block accepts the operand set this cycle.
REQ-008 Port a_i, input, NCH*WIDTH: channel c A operand at bits [c*WIDTH +: WIDTH].
REQ-009 Port b_i, input, NCH*WIDTH: channel c B operand, packed the same way.
REQ-010 Port sel_i, input, NCH*3: channel c opcode at bits [c*3 +: 3].
REQ-011 Port acc_en_i, input, NCH: per-channel accumulate-mode request.
REQ-012 Port out_valid, output, 1: the result set is valid.
REQ-013 Port out_ready, input, 1: the consumer accepts the result set.
REQ-014 Port res_o, output, NCH*WIDTH: channel results, packed the same way as a_i.
REQ-015 Port carry_o, output, NCH: per-channel carry/borrow/shift-out flag.
REQ-016 Port x_o, output, WIDTH: bitwise XOR of all channel results.
REQ-017 Port y_o, output, 1: reduction XOR of x_o.
REQ-018 Port txn_cnt_o, output, 16: count of completed output handshakes.
REQ-019 Port io_oeb_o, output, NCH*WIDTH+NCH+WIDTH+1: pad output-enable-bar, one bit per result, carry, x and y pad.

Function
REQ-020 The datapath SHALL be a 2-stage pipeline: S1 registers the accepted operands, sel and acc_en; S2 registers the computed results.
REQ-021 An input transfer SHALL occur when in_valid && in_ready.
REQ-022 An output transfer SHALL occur when out_valid && out_ready.
REQ-023 S2 SHALL advance when active && (!s2_valid || out_ready).
REQ-024 S1 SHALL advance when active && (!s1_valid || S2 advances).
REQ-025 in_ready SHALL equal active && (!s1_valid || S2 advances).
REQ-026 The latency SHALL be 2: an input transfer at cycle N SHALL make out_valid high at cycle N+2 when no stall occurs.
REQ-027 The block SHALL sustain full throughput of 1 transfer per cycle.
REQ-028 Under backpressure the pipeline SHALL hold at most 2 entries, with no loss, duplication or reordering.
REQ-029 Opcodes, all WIDTH-bit modulo:
- 000 add: carry = bit WIDTH of A+B.
- 001 sub: carry = bit WIDTH of A+~B+1 (1 = no borrow).
- 010 AND.
- 011 OR.
- 100 XOR.
- 101 NOT A.
- 110 shl by 1: carry = A msb.
- 111 shr by 1: carry = A lsb.
- Carry SHALL be 0 for opcodes 010-101.
REQ-030 Each channel SHALL keep a WIDTH-bit acc_q, loaded with that channel's result on every S2 advance that carries a valid entry.
REQ-031 When the S1 entry's acc_en[c] is 1, channel c SHALL use acc_q[c] in place of A.
- acc_q[c] is the value at the cycle S1 advances into S2, so back-to-back accumulate entries chain correctly.
REQ-032 x_o and y_o SHALL be derived combinationally from the S2 registers.
REQ-033 txn_cnt_o SHALL increment by 1 on every output transfer and wrap from 0xFFFF to 0x0000.
REQ-034 When active=0:
- in_ready, out_valid, res_o, carry_o, x_o and y_o SHALL read 0.
- io_oeb_o SHALL be all 1.
- All pipeline, acc_q and counter state SHALL hold.
- Output values and handshakes SHALL resume unchanged when active returns to 1.
REQ-035 When active=1, io_oeb_o SHALL be all 0.

Reset
REQ-036 Asserting wb_rst_ni low SHALL immediately clear s1_valid, s2_valid, all data registers, acc_q and txn_cnt_o to 0.
- This holds regardless of wb_clk_i.
- Any in-flight entries SHALL be discarded.
REQ-037 The first input transfer SHALL be possible on the first clock edge after reset deassertion with active=1.

Verification
REQ-038 WIDTH=4, NCH=2; ch0 add A=0xF B=0x1, ch1 sub A=0x3 B=0x5 -> after 2 cycles res0=0x0 carry0=1, res1=0xE carry1=0, x_o=0xE, y_o=1.
REQ-039 out_ready=0, in_valid=1 for 4 cycles with A=1,2,3,4 -> exactly 2 accepted, in_ready=0 thereafter; with out_ready=1, outputs appear in order 1,2, then input resumes.
REQ-040 After reset, ch0 acc_en=1 add B=0x1 for 3 consecutive transfers -> results 0x1,0x2,0x3; a following shl with acc_en -> 0x6, carry 0.
REQ-041 Two entries in flight, wb_rst_ni pulsed low mid-cycle -> out_valid and txn_cnt_o are 0 immediately; no stale result emerges afterward.
REQ-042 active dropped for 5 cycles with out_valid=1 -> outputs 0, io_oeb_o all 1, in_ready 0; on reassertion the same result and count reappear.
REQ-043 Counter preloaded to 0xFFFE via 2 transfers past 0xFFFE -> txn_cnt_o reads 0xFFFF, then 0x0000.
